fetch_ctrl: RTL and testbench

Instruction fetch controller for the CPU front end. It owns the program counter register and drives a one-outstanding request/response handshake to instruction memory. It presents each fetched instruction, with its PC and PC+4, to decode under a valid/ready handshake. It applies redirects from branch/jump resolution, including while a memory request is still in flight.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/pc_incr.sv | 11 +
 rtl/fetch_ctrl.sv | 158 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// The redirect alignment check is enabled by defining FETCH_ALIGN_CHECK_EN.
package fetch_pkg;

    localparam int          INSN_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DROP
    } fetch_state_e;

endpackage

// File: rtl/pc_incr.sv
// Combinational +4 adder for instruction addresses; wraps modulo 2^32 with no carry out.
module pc_incr
    import fetch_pkg::*;
(
    input  logic [INSN_W-1:0] addr,
    output logic [INSN_W-1:0] sum
);

    assign sum = addr + INSN_W'(4);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the PC, runs a one-outstanding imem handshake
// and hands instructions to decode. Optional redirect alignment check: FETCH_ALIGN_CHECK_EN.
module fetch_ctrl
    import fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [INSN_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [INSN_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INSN_W-1:0] inst,
    output logic [INSN_W-1:0] pc_out,
    output logic [INSN_W-1:0] pc_plus4,
    input  logic              redir_valid,
    input  logic [INSN_W-1:0] redir_target,
    output logic              fetch_err
);

    fetch_state_e      state, state_next;
    logic [INSN_W-1:0] pc, pc_next;
    logic [INSN_W-1:0] pend, pend_next;
    logic [INSN_W-1:0] pc_seq;
    logic [INSN_W-1:0] redir_addr;
    logic [INSN_W-1:0] jump_addr;
    logic              jump;
    logic              capture;

    pc_incr u_pc_seq (
        .addr (pc),
        .sum  (pc_seq)
    );

    pc_incr u_pc_plus4 (
        .addr (pc_out),
        .sum  (pc_plus4)
    );

`ifdef FETCH_ALIGN_CHECK_EN
    logic err_q, err_next;

    assign redir_addr = redir_target;
    assign fetch_err  = err_q;
`else
    // Without the check, low address bits are simply ignored.
    assign redir_addr = redir_target & ~INSN_W'(3);
    assign fetch_err  = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        pend_next  = pend;
        jump       = 1'b0;
        jump_addr  = redir_addr;
        capture    = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        err_next   = err_q;
`endif

        case (state)
            IDLE: begin
                if (redir_valid) begin
                    jump = 1'b1;
                end else begin
`ifdef FETCH_ALIGN_CHECK_EN
                    if (!err_q) state_next = REQ;
`else
                    state_next = REQ;
`endif
                end
            end
            REQ: begin
                if (redir_valid) begin
                    if (imem_rvalid) begin
                        jump = 1'b1;
                    end else begin
                        pend_next  = redir_addr;
                        state_next = DROP;
                    end
                end else if (imem_rvalid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redir_valid) begin
                    jump = 1'b1;
                end else if (inst_ready) begin
                    pc_next    = pc_seq;
                    state_next = REQ;
                end
            end
            DROP: begin
                // The old response must land before the pending target can be fetched.
                if (imem_rvalid) begin
                    jump      = 1'b1;
                    jump_addr = redir_valid ? redir_addr : pend;
                end else if (redir_valid) begin
                    pend_next = redir_addr;
                end
            end
            default: state_next = IDLE;
        endcase

        if (jump) begin
            pc_next = jump_addr;
`ifdef FETCH_ALIGN_CHECK_EN
            if (jump_addr[1:0] != 2'b00) begin
                state_next = IDLE;
                err_next   = 1'b1;
            end else begin
                state_next = REQ;
                err_next   = 1'b0;
            end
`else
            state_next = REQ;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            pend       <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_valid <= 1'b0;
            inst       <= '0;
            pc_out     <= RESET_PC;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            pend       <= pend_next;
            imem_req   <= (state_next == REQ) || (state_next == DROP);
            inst_valid <= (state_next == HOLD);
            // The in-flight address is frozen while a dropped response is awaited.
            if (state_next != DROP) imem_addr <= pc_next;
            if (capture) begin
                inst   <= imem_rdata;
                pc_out <= pc;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_next;
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus random traffic
// checked against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        fetch_err;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .fetch_err    (fetch_err)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Memory latency window (cycles after the first req cycle).
    int lat_lo = 0;
    int lat_hi = 0;

    // Reference model: what the next cycle should look like, in fetch-stream terms.
    logic [31:0] exp_pc;
    logic [31:0] pend_tgt;
    logic [31:0] prev_addr;
    bit          exp_req, exp_valid, exp_err, pend_v, prev_req, prev_rv;
    int          req_age, lat;
    logic [31:0] acc_pc_q[$];
    logic [31:0] acc_p4_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic apply_redirect(input logic [31:0] t);
`ifdef FETCH_ALIGN_CHECK_EN
        exp_pc  = t;
        exp_err = (t[1:0] != 2'b00);
`else
        exp_pc  = {t[31:2], 2'b00};
        exp_err = 1'b0;
`endif
    endtask

    task automatic model_reset();
        exp_pc    = 32'h0000_3000;
        exp_err   = 1'b0;
        exp_req   = 1'b1;
        exp_valid = 1'b0;
        pend_v    = 1'b0;
        pend_tgt  = '0;
        prev_req  = 1'b0;
        prev_rv   = 1'b0;
        prev_addr = '0;
        req_age   = 0;
        lat       = 0;
        acc_pc_q.delete();
        acc_p4_q.delete();
    endtask

    task automatic drive_idle();
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        inst_ready   = 1'b0;
        redir_valid  = 1'b0;
        redir_target = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    // One clock of traffic: compare outputs against the model, play memory,
    // drive decode/redirect inputs, advance the model, then move to the next cycle.
    task automatic step(input bit redir, input logic [31:0] tgt, input bit rdy);
        bit rv, acc, busy, nr, nv;
        vectors++;
        if (imem_req !== exp_req) begin
            miscompares++;
            $display("FAIL imem_req @%0t: got %b expected %b", $time, imem_req, exp_req);
        end
        vectors++;
        if (inst_valid !== exp_valid) begin
            miscompares++;
            $display("FAIL inst_valid @%0t: got %b expected %b", $time, inst_valid, exp_valid);
        end
        vectors++;
        if (fetch_err !== exp_err) begin
            miscompares++;
            $display("FAIL fetch_err @%0t: got %b expected %b", $time, fetch_err, exp_err);
        end
        if (imem_req === 1'b1) begin
            if (!prev_req || prev_rv) begin
                vectors++;
                if (imem_addr !== exp_pc) begin
                    miscompares++;
                    $display("FAIL req_addr @%0t: got %h expected %h", $time, imem_addr, exp_pc);
                end
                req_age = 0;
                lat = $urandom_range(lat_hi, lat_lo);
            end else begin
                vectors++;
                if (imem_addr !== prev_addr) begin
                    miscompares++;
                    $display("FAIL addr_stable @%0t: got %h expected %h", $time, imem_addr, prev_addr);
                end
                req_age++;
            end
        end
        rv  = (imem_req === 1'b1) && (req_age >= lat);
        acc = (inst_valid === 1'b1) && rdy && !redir;
        if (acc) begin
            vectors++;
            if (pc_out !== exp_pc) begin
                miscompares++;
                $display("FAIL pc_out @%0t: got %h expected %h", $time, pc_out, exp_pc);
            end
            vectors++;
            if (inst !== mem_word(exp_pc)) begin
                miscompares++;
                $display("FAIL inst @%0t: got %h expected %h", $time, inst, mem_word(exp_pc));
            end
            vectors++;
            if (pc_plus4 !== exp_pc + 32'd4) begin
                miscompares++;
                $display("FAIL pc_plus4 @%0t: got %h expected %h", $time, pc_plus4, exp_pc + 32'd4);
            end
            acc_pc_q.push_back(pc_out);
            acc_p4_q.push_back(pc_plus4);
        end

        busy = (imem_req === 1'b1) && !rv;
        nr   = busy;
        nv   = 1'b0;
        if (redir) begin
            if (busy) begin
                pend_v   = 1'b1;
                pend_tgt = tgt;
            end else begin
                pend_v = 1'b0;
                apply_redirect(tgt);
                nr = !exp_err;
            end
        end else if (rv) begin
            if (pend_v) begin
                pend_v = 1'b0;
                apply_redirect(pend_tgt);
                nr = !exp_err;
            end else begin
                nv = 1'b1;
            end
        end else if (acc) begin
            exp_pc = exp_pc + 32'd4;
            nr = 1'b1;
        end else if (inst_valid === 1'b1) begin
            nv = 1'b1;
        end
        exp_req   = nr;
        exp_valid = nv;
        prev_req  = (imem_req === 1'b1);
        prev_rv   = rv;
        prev_addr = imem_addr;

        imem_rvalid  = rv;
        imem_rdata   = rv ? mem_word(imem_addr) : $urandom();
        inst_ready   = rdy;
        redir_valid  = redir;
        redir_target = tgt;
        @(negedge clk);
    endtask

    task automatic wait_accepts(input int n, input int budget, input string tag);
        int k;
        for (k = 0; k < budget && acc_pc_q.size() < n; k++) step(1'b0, '0, 1'b1);
        if (acc_pc_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: got %0d accepts expected %0d", tag, acc_pc_q.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        redir_valid  = 1'b1;
        redir_target = 32'h1234_5678;
        imem_rvalid  = 1'b1;
        imem_rdata   = 32'hDEAD_BEEF;
        inst_ready   = 1'b1;
        repeat (2) @(negedge clk);
        vectors += 7;
        if (imem_req !== 1'b0)              begin miscompares++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        if (imem_addr !== 32'h0000_3000)    begin miscompares++; $display("FAIL rst_addr: got %h expected 00003000", imem_addr); end
        if (inst_valid !== 1'b0)            begin miscompares++; $display("FAIL rst_valid: got %b expected 0", inst_valid); end
        if (inst !== 32'h0)                 begin miscompares++; $display("FAIL rst_inst: got %h expected 0", inst); end
        if (pc_out !== 32'h0000_3000)       begin miscompares++; $display("FAIL rst_pc_out: got %h expected 00003000", pc_out); end
        if (pc_plus4 !== 32'h0000_3004)     begin miscompares++; $display("FAIL rst_pc_plus4: got %h expected 00003004", pc_plus4); end
        if (fetch_err !== 1'b0)             begin miscompares++; $display("FAIL rst_err: got %b expected 0", fetch_err); end
        drive_idle();
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            miscompares++;
            $display("FAIL first_req: got %b/%h expected 1/00003000", imem_req, imem_addr);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] want;
        do_reset();
        lat_lo = 0;
        lat_hi = 0;
        for (int i = 0; i < 6; i++) begin
            want = 32'h0000_3000 + 32'(4 * (i / 2));
            vectors++;
            if (imem_req !== (i % 2 == 0) || inst_valid !== (i % 2 == 1)) begin
                miscompares++;
                $display("FAIL zw_pattern[%0d]: got req=%b valid=%b expected req=%b", i, imem_req, inst_valid, (i % 2 == 0));
            end
            vectors++;
            if (i % 2 == 0 && imem_addr !== want) begin
                miscompares++;
                $display("FAIL zw_addr[%0d]: got %h expected %h", i, imem_addr, want);
            end else if (i % 2 == 1 && pc_plus4 !== want + 32'd4) begin
                miscompares++;
                $display("FAIL zw_plus4[%0d]: got %h expected %h", i, pc_plus4, want + 32'd4);
            end
            step(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_latency_stall();
        logic [31:0] held;
        int k;
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        for (k = 0; k < 20 && inst_valid !== 1'b1; k++) step(1'b0, '0, 1'b0);
        vectors++;
        if (inst_valid !== 1'b1 || k != 4) begin
            miscompares++;
            $display("FAIL lat_arrival: got valid=%b after %0d cycles expected 1 after 4", inst_valid, k);
        end
        held = inst;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (inst_valid !== 1'b1 || imem_req !== 1'b0 || inst !== mem_word(32'h0000_3000) || inst !== held) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got valid=%b req=%b inst=%h expected 1/0/%h", i, inst_valid, imem_req, inst, mem_word(32'h0000_3000));
            end
            step(1'b0, '0, 1'b0);
        end
        step(1'b0, '0, 1'b1);
        vectors++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3004) begin
            miscompares++;
            $display("FAIL stall_next: got %b/%h expected 1/00003004", imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_inflight();
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_4000, 1'b1);
        wait_accepts(1, 40, "inflight");
        if (acc_pc_q.size() >= 1) begin
            vectors++;
            if (acc_pc_q[0] !== 32'h0000_4000) begin
                miscompares++;
                $display("FAIL inflight_pc: got %h expected 00004000", acc_pc_q[0]);
            end
        end
    endtask

    task automatic test_double_redirect();
        do_reset();
        lat_lo = 4;
        lat_hi = 4;
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_5000, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b1, 32'h0000_6000, 1'b1);
        wait_accepts(2, 40, "double");
        if (acc_pc_q.size() >= 2) begin
            vectors++;
            if (acc_pc_q[0] !== 32'h0000_6000 || acc_pc_q[1] !== 32'h0000_6004) begin
                miscompares++;
                $display("FAIL double_pc: got %h,%h expected 00006000,00006004", acc_pc_q[0], acc_pc_q[1]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        lat_lo = 0;
        lat_hi = 0;
        step(1'b1, 32'hFFFF_FFFC, 1'b1);
        wait_accepts(2, 20, "wrap");
        if (acc_pc_q.size() >= 2) begin
            vectors++;
            if (acc_pc_q[0] !== 32'hFFFF_FFFC || acc_p4_q[0] !== 32'h0 || acc_pc_q[1] !== 32'h0) begin
                miscompares++;
                $display("FAIL wrap: got pc=%h plus4=%h next=%h expected FFFFFFFC/00000000/00000000", acc_pc_q[0], acc_p4_q[0], acc_pc_q[1]);
            end
        end
    endtask

    task automatic test_align();
        int k;
        do_reset();
        lat_lo = 1;
        lat_hi = 1;
        for (k = 0; k < 20 && inst_valid !== 1'b1; k++) step(1'b0, '0, 1'b0);
        step(1'b1, 32'h0000_4002, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
                miscompares++;
                $display("FAIL align_err[%0d]: got err=%b req=%b expected 1/0", i, fetch_err, imem_req);
            end
            step(1'b0, '0, 1'b1);
        end
        step(1'b1, 32'h0000_4004, 1'b1);
        wait_accepts(1, 20, "align");
        if (acc_pc_q.size() >= 1) begin
            vectors++;
            if (acc_pc_q[0] !== 32'h0000_4004 || fetch_err !== 1'b0) begin
                miscompares++;
                $display("FAIL align_resume: got pc=%h err=%b expected 00004004/0", acc_pc_q[0], fetch_err);
            end
        end
`else
        wait_accepts(1, 20, "align");
        if (acc_pc_q.size() >= 1) begin
            vectors++;
            if (acc_pc_q[0] !== 32'h0000_4000 || fetch_err !== 1'b0) begin
                miscompares++;
                $display("FAIL align_mask: got pc=%h err=%b expected 00004000/0", acc_pc_q[0], fetch_err);
            end
        end
`endif
    endtask

    task automatic test_reset_midreq();
        do_reset();
        lat_lo = 3;
        lat_hi = 3;
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        #2;
        rst_n = 1'b0;
        drive_idle();
        #1;
        vectors++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 32'h0000_3000) begin
            miscompares++;
            $display("FAIL midreq_reset: got req=%b valid=%b addr=%h expected 0/0/00003000", imem_req, inst_valid, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        wait_accepts(1, 20, "midreq");
        if (acc_pc_q.size() >= 1) begin
            vectors++;
            if (acc_pc_q[0] !== 32'h0000_3000) begin
                miscompares++;
                $display("FAIL midreq_restart: got %h expected 00003000", acc_pc_q[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] tmp, tgt;
        bit          rdy, redir;
        do_reset();
        lat_lo = 0;
        lat_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            rdy   = ($urandom_range(99, 0) < 65);
            redir = ($urandom_range(99, 0) < 7);
            tmp   = $urandom();
            case ($urandom_range(7, 0))
                0:       tgt = 32'hFFFF_FFF8;
                1:       tgt = tmp;
                default: tgt = {tmp[31:2], 2'b00};
            endcase
            step(redir, tgt, rdy);
        end
        vectors++;
        if (acc_pc_q.size() < 200) begin
            miscompares++;
            $display("FAIL random_progress: got %0d accepts expected at least 200", acc_pc_q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        drive_idle();
        test_reset();
        test_zero_wait();
        test_latency_stall();
        test_redirect_inflight();
        test_double_redirect();
        test_wrap();
        test_align();
        test_reset_midreq();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
